// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions for the pipeline stages.
//   lc3b_word          16-bit datapath word
//   lc3b_opcode        4-bit instruction opcode with named constants
//   mem_stage_state_t  sequencing states of the memory stage
// Helpers classify opcodes by their memory behaviour.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_INDIRECT,
    S_DONE
  } mem_stage_state_t;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return op inside {op_ldr, op_ldb, op_str, op_stb, op_ldi, op_sti, op_trap};
  endfunction

  function automatic logic is_store_op(input lc3b_opcode op);
    return op inside {op_str, op_stb, op_sti};
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering between the 16-bit memory port and byte operations.
//   addr_lsb     byte address bit (1 = high byte)
//   byte_op      1 for LDB/STB, 0 for word operations
//   load_raw     word returned by memory
//   store_data   register data to be stored
//   load_data    selected and sign-extended (byte) or raw (word) load result
//   store_wdata  replicated (byte) or raw (word) write data
//   store_be     write byte-lane mask
module mem_byte_align
  import lc3b_types::*;
(
  input  logic       addr_lsb,
  input  logic       byte_op,
  input  lc3b_word   load_raw,
  input  lc3b_word   store_data,
  output lc3b_word   load_data,
  output lc3b_word   store_wdata,
  output logic [1:0] store_be
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte    = addr_lsb ? load_raw[15:8] : load_raw[7:0];
    load_data   = load_raw;
    store_wdata = store_data;
    store_be    = 2'b11;
    if (byte_op) begin
      load_data   = {{8{sel_byte[7]}}, sel_byte};
      // Byte stores put the byte on both lanes; the mask picks the real one.
      store_wdata = {store_data[7:0], store_data[7:0]};
      store_be    = addr_lsb ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b pipeline memory stage: issues one memory access per buffered
// memory instruction, stalls upstream until it completes, pulses done.
//   clk, reset        rising-edge clock, async active-high reset
//   valid_in          stage buffer holds a live instruction
//   opcode_in         buffered opcode
//   mar_in, mdr_in    effective address and store data
//   mem_rdata/resp    memory read data and one-cycle completion strobe
//   mem_read/write    request strobes, held until mem_resp
//   mem_address       word-aligned address
//   mem_byte_enable   write lane mask
//   mem_wdata         write data
//   stall             holds the upstream buffer
//   mem_data_out      registered load result
//   done              one-cycle completion pulse
//   mem_error         sticky timeout flag
// Parameter TIMEOUT: cycles per phase before abort (0 = never).
// Macro LDI_STI_EN: two-phase indirect LDI/STI; otherwise they act as LDR/STR.
module mem_stage
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  lc3b_opcode opcode_in,
  input  lc3b_word   mar_in,
  input  lc3b_word   mdr_in,
  input  lc3b_word   mem_rdata,
  input  logic       mem_resp,
  output logic       mem_read,
  output logic       mem_write,
  output lc3b_word   mem_address,
  output logic [1:0] mem_byte_enable,
  output lc3b_word   mem_wdata,
  output logic       stall,
  output lc3b_word   mem_data_out,
  output logic       done,
  output logic       mem_error
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_stage_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  lc3b_word         data_q, data_d;
  logic             err_q, err_d;
`ifdef LDI_STI_EN
  // Pointer is kept as a word index; the indirect access is word-aligned.
  logic [14:0]      ptr_q, ptr_d;
  logic             indirect_op;
`endif

  lc3b_word   align_load, align_wdata;
  logic [1:0] align_be;
  logic       byte_op, phase_write, timed_out;

  assign byte_op = (opcode_in == op_ldb) || (opcode_in == op_stb);

  mem_byte_align u_align (
    .addr_lsb    (mar_in[0]),
    .byte_op     (byte_op),
    .load_raw    (mem_rdata),
    .store_data  (mdr_in),
    .load_data   (align_load),
    .store_wdata (align_wdata),
    .store_be    (align_be)
  );

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

`ifdef LDI_STI_EN
  assign indirect_op = (opcode_in == op_ldi) || (opcode_in == op_sti);
  // The pointer fetch of an indirect store is a read.
  assign phase_write = is_store_op(opcode_in) && !(state_q == S_ACCESS && indirect_op);
`else
  assign phase_write = is_store_op(opcode_in);
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    err_d           = err_q;
`ifdef LDI_STI_EN
    ptr_d           = ptr_q;
`endif
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    stall           = 1'b0;
    done            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in && is_mem_op(opcode_in)) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS, S_INDIRECT: begin
        stall       = 1'b1;
        mem_address = {mar_in[15:1], 1'b0};
`ifdef LDI_STI_EN
        if (state_q == S_INDIRECT) mem_address = {ptr_q, 1'b0};
`endif
        if (phase_write) begin
          mem_write       = 1'b1;
          mem_wdata       = align_wdata;
          mem_byte_enable = align_be;
        end else begin
          mem_read        = 1'b1;
          mem_byte_enable = 2'b11;
        end

        if (mem_resp) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!phase_write) data_d = align_load;
`ifdef LDI_STI_EN
          if (state_q == S_ACCESS && indirect_op) begin
            ptr_d   = mem_rdata[15:1];
            data_d  = data_q;
            state_d = S_INDIRECT;
          end
`endif
        end else if (timed_out) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Reset forces IDLE, but stall would still follow valid_in combinationally.
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef LDI_STI_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef LDI_STI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign mem_data_out = data_q;
  assign mem_error    = err_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of cycles to wait for mem_resp in one phase before aborting; 0 disables the timeout.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port valid_in, input, 1 bit: the upstream stage buffer holds a live instruction.
REQ-006 SHALL have port opcode_in, input, lc3b_opcode (4 bits): opcode of the buffered instruction.
REQ-007 SHALL have port mar_in, input, 16 bits: effective address from the stage buffer.
REQ-008 SHALL have port mdr_in, input, 16 bits: store data from the stage buffer.
REQ-009 SHALL have port mem_rdata, input, 16 bits: memory read data.
REQ-010 SHALL have port mem_resp, input, 1 bit: memory completion strobe, one cycle wide.
REQ-011 SHALL have ports mem_read and mem_write, output, 1 bit each: memory request strobes.
REQ-012 SHALL have port mem_address, output, 16 bits: word-aligned memory address.
REQ-013 SHALL have port mem_byte_enable, output, 2 bits: byte-lane write mask.
REQ-014 SHALL have port mem_wdata, output, 16 bits: memory write data.
REQ-015 SHALL have port stall, output, 1 bit: holds the upstream buffer load low while asserted.
REQ-016 SHALL have port mem_data_out, output, 16 bits: load result passed to the next stage buffer.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port mem_error, output, 1 bit: sticky timeout flag.

Function
REQ-019 SHALL treat LDR, LDB, STR, STB, LDI, STI and TRAP as memory operations; all other opcodes pass with stall=0 and no request.
REQ-020 SHALL implement the states IDLE, ACCESS, INDIRECT and DONE.
REQ-021 SHALL, in IDLE with valid_in=1 and a memory opcode, assert stall combinationally in that cycle and enter ACCESS at the next edge.
REQ-022 SHALL hold mem_read or mem_write high in ACCESS and INDIRECT, with mem_address, mem_wdata and mem_byte_enable stable, until the cycle mem_resp=1.
REQ-023 SHALL ignore mem_resp in IDLE and DONE.
REQ-024 SHALL set mem_address to {mar_in[15:1],0} and byte enable 2'b11 for word operations.
REQ-025 SHALL, for STB, set mem_byte_enable to 2'b10 if mar_in[0]=1 and to 2'b01 otherwise, with mem_wdata = {mdr_in[7:0],mdr_in[7:0]}.
REQ-026 SHALL, for LDB, select the high byte if mar_in[0]=1 and the low byte otherwise, sign-extended to 16 bits.
REQ-027 SHALL treat TRAP as a word read at mar_in, with the vector returned on mem_data_out.
REQ-028 SHALL, on mem_resp for a single-phase operation, register the load data into mem_data_out and enter DONE.
REQ-029 SHALL, in DONE, drive stall=0 and done=1 for exactly one cycle, then return to IDLE unconditionally, so the same instruction is never re-issued.
REQ-030 SHALL give a single-phase operation a latency of (cycles to mem_resp) + 2 cycles from valid_in to done.
REQ-031 SHALL keep a per-phase wait counter when TIMEOUT != 0; on reaching TIMEOUT it drops the request, sets mem_error, forces mem_data_out=0x0000, and enters DONE.
REQ-032 SHALL leave mem_data_out unchanged for stores and non-memory operations.

Reset
REQ-033 SHALL, on reset assertion even mid-access, immediately enter IDLE and clear mem_read, mem_write, stall, done, mem_error, the counter and the pointer register; mem_data_out, mem_address and mem_wdata clear to 0x0000 and mem_byte_enable to 2'b00.

Configuration
REQ-034 SHALL, with LDI_STI_EN defined, perform LDI/STI as two phases: ACCESS reads the pointer at mar_in into a register, then INDIRECT reads (LDI) or writes mdr_in (STI) at the word-aligned pointer.
REQ-035 SHALL, with LDI_STI_EN undefined, omit INDIRECT and the pointer register, and perform LDI/STI as single-phase LDR/STR at mar_in.

Structure
REQ-036 SHALL place lc3b_word, lc3b_opcode, the opcode constants and a new mem_stage_state_t enum in the shared lc3b_types package.
REQ-037 SHALL implement load byte select/sign-extend and store replicate/mask generation in one combinational sub-module, mem_byte_align.

Verification
REQ-038 SHALL verify LDR with mar_in=0x1235 and mem_resp after 3 cycles: mem_address=0x1234, stall high for 4 cycles, done pulses, mem_data_out equals mem_rdata.
REQ-039 SHALL verify LDB with mar_in=0x2001 and mem_rdata=0x80FF: mem_data_out=0xFF80; STB with mar_in=0x2001 and mdr_in=0x00AB: byte_enable=2'b10, wdata=0xABAB.
REQ-040 SHALL verify STI with LDI_STI_EN defined, mar_in=0x3000, memory returning 0x4002, mdr_in=0x5555: a read at 0x3000 then a write of 0x5555 at 0x4002, and exactly one done pulse.
REQ-041 SHALL verify ADD with valid_in=1: stall=0, no mem_read or mem_write, and mem_data_out unchanged.
REQ-042 SHALL verify a TIMEOUT=4 run with no mem_resp: the request drops after 4 cycles, mem_error=1, mem_data_out=0x0000, and done pulses.
REQ-043 SHALL verify reset asserted while mem_read is high: all outputs clear in the same cycle, and the next instruction issues normally.
